// File: rtl/fft_sequencer.sv
// Control sequencer for one radix-2 DIT FFT frame. It loads samples at bit-reversed addresses,
// issues butterfly pairs stage by stage, then drains the frame in natural order.
module fft_sequencer #(
    parameter int unsigned SAMPLES  = 8,
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned BFLY_LAT = 2,
    localparam int unsigned L       = $clog2(SAMPLES),
    localparam int unsigned SW      = $clog2(L) + 1,
    localparam int unsigned GW      = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             wr_en,
    output logic [L-1:0]     wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             bfly_valid,
    input  logic             bfly_ready,
    output logic [L-1:0]     bfly_addr_a,
    output logic [L-1:0]     bfly_addr_b,
    output logic [L-2:0]     twiddle_idx,
    output logic [SW-1:0]    stage,
    output logic             rd_en,
    output logic [L-1:0]     rd_addr,
    output logic             out_valid,
    output logic [L-1:0]     out_index,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {StIdle, StLoad, StCompute, StGap, StDrain, StFlush} state_e;

    localparam logic [L-1:0]  LastIdx = L'(SAMPLES - 1);
    localparam logic [L-1:0]  LastJ   = L'(SAMPLES / 2 - 1);
    localparam logic [SW-1:0] LastS   = SW'(L - 1);
    localparam logic [GW-1:0] LastGap = GW'(BFLY_LAT - 1);

    state_e state_q, state_d;
    logic [L-1:0]     idx_q, idx_d;
    logic [SW-1:0]    s_q, s_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             wr_en_q, wr_en_d;
    logic [L-1:0]     wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             out_valid_q, out_valid_d;
    logic [L-1:0]     out_index_q, out_index_d;
    logic             done_q, done_d;

    logic             accept;
    logic             issue;
    logic [L-1:0]     h, k, base;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int b = 0; b < int'(L); b++) begin
            r[b] = v[int'(L) - 1 - b];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StLoad;
            StLoad:    if (in_valid && idx_q == LastIdx) state_d = StCompute;
            StCompute: if (bfly_ready && idx_q == LastJ) state_d = (s_q == LastS) ? StDrain : StGap;
            StGap:     if (gap_q == LastGap) state_d = StCompute;
            StDrain:   if (idx_q == LastIdx) state_d = StFlush;
            StFlush:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign accept = (state_q == StLoad) && in_valid;
    assign issue  = (state_q == StCompute) && bfly_ready;

    // idx is the sample index in LOAD, j in COMPUTE and the read address in DRAIN.
    always_comb begin
        idx_d = idx_q;
        s_d   = s_q;
        gap_d = gap_q;
        if (state_d != state_q) begin
            idx_d = '0;
            gap_d = '0;
        end else if (accept || issue || state_q == StDrain) begin
            idx_d = idx_q + L'(1);
        end else if (state_q == StGap) begin
            gap_d = gap_q + GW'(1);
        end
        if (state_q == StIdle) begin
            s_d = '0;
        end else if (state_q == StGap && state_d == StCompute) begin
            s_d = s_q + SW'(1);
        end
    end

    always_comb begin
        wr_en_d     = accept;
        wr_addr_d   = accept ? bitrev(idx_q) : '0;
        wr_data_d   = accept ? in_data : '0;
        out_valid_d = rd_en;
        out_index_d = rd_addr;
        done_d      = (state_q == StFlush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            s_q         <= '0;
            gap_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            s_q         <= s_d;
            gap_q       <= gap_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
        end
    end

    // Butterfly pair for group j/h, offset k within a group of span 2h.
    always_comb begin
        h    = L'(1) << s_q;
        k    = idx_q & (h - L'(1));
        base = (idx_q >> s_q) << (s_q + SW'(1));
    end

    always_comb begin
        in_ready    = (state_q == StLoad);
        bfly_valid  = (state_q == StCompute);
        bfly_addr_a = '0;
        bfly_addr_b = '0;
        twiddle_idx = '0;
        stage       = '0;
        if (state_q == StCompute) begin
            bfly_addr_a = base | k;
            bfly_addr_b = base | k | h;
            twiddle_idx = (L-1)'(k << (LastS - s_q));
            stage       = s_q;
        end
        rd_en     = (state_q == StDrain);
        rd_addr   = (state_q == StDrain) ? idx_q : '0;
        busy      = (state_q != StIdle);
        wr_en     = wr_en_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        out_valid = out_valid_q;
        out_index = out_index_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed self-checking bench for fft_sequencer with SAMPLES=8, WIDTH=3, BFLY_LAT=2.
module tb_fft_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, bfly_ready;
    logic [2:0] in_data;
    logic       in_ready, wr_en, bfly_valid, rd_en, out_valid, busy, done;
    logic [2:0] wr_addr, wr_data, bfly_addr_a, bfly_addr_b, rd_addr, out_index, stage;
    logic [1:0] twiddle_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int bitrev_tab [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int exp_a      [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b      [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_t      [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_sequencer #(
        .SAMPLES (8),
        .WIDTH   (3),
        .BFLY_LAT(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bfly_valid (bfly_valid),
        .bfly_ready (bfly_ready),
        .bfly_addr_a(bfly_addr_a),
        .bfly_addr_b(bfly_addr_b),
        .twiddle_idx(twiddle_idx),
        .stage      (stage),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check(tag, 32'({busy, in_ready, wr_en, bfly_valid, rd_en, out_valid, done, wr_addr,
                        wr_data, bfly_addr_a, bfly_addr_b, twiddle_idx, stage, rd_addr,
                        out_index}), 32'd0);
    endtask

    task automatic load_samples();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_to_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 3'(i);
            check("load_ready", 32'(in_ready), 32'd1);
            step();
            check("wr_en", 32'(wr_en), 32'd1);
            check("wr_addr", 32'(wr_addr), 32'(bitrev_tab[i]));
            check("wr_data", 32'(wr_data), 32'(i));
        end
        in_valid = 1'b0;
        check("ready_drop", 32'(in_ready), 32'd0);
    endtask

    task automatic check_pair(input int e, input int s);
        check("bfly_valid", 32'(bfly_valid), 32'd1);
        check("bfly_a", 32'(bfly_addr_a), 32'(exp_a[e]));
        check("bfly_b", 32'(bfly_addr_b), 32'(exp_b[e]));
        check("twiddle", 32'(twiddle_idx), 32'(exp_t[e]));
        check("stage", 32'(stage), 32'(s));
    endtask

    task automatic run_frame(input bit stall, input bit stray, input int exp_len);
        int t0;
        t0 = cyc;
        load_samples();
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 4; j++) begin
                start = stray;
                if (stall && s == 1 && j == 1) begin
                    bfly_ready = 1'b0;
                    repeat (3) begin
                        check_pair(s * 4 + j, s);
                        step();
                    end
                    bfly_ready = 1'b1;
                end
                check_pair(s * 4 + j, s);
                step();
            end
            start = 1'b0;
            if (s < 2) begin
                repeat (2) begin
                    check("gap_valid", 32'(bfly_valid), 32'd0);
                    check("gap_busy", 32'(busy), 32'd1);
                    step();
                end
            end
        end
        for (int d = 0; d < 8; d++) begin
            in_valid = stray;
            in_data  = 3'd5;
            check("rd_en", 32'(rd_en), 32'd1);
            check("rd_addr", 32'(rd_addr), 32'(d));
            check("drain_out_valid", 32'(out_valid), (d > 0) ? 32'd1 : 32'd0);
            if (d > 0) check("out_index", 32'(out_index), 32'(d - 1));
            check("drain_no_ready", 32'(in_ready), 32'd0);
            check("drain_no_wr", 32'(wr_en), 32'd0);
            step();
        end
        in_valid = 1'b0;
        check("flush_rd_en", 32'(rd_en), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd1);
        check("flush_out_index", 32'(out_index), 32'd7);
        check("flush_done", 32'(done), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        step();
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("frame_len", 32'(cyc - t0 + 1), 32'(exp_len));
        step();
        check("done_single", 32'(done), 32'd0);
        check_idle("post_frame_idle");
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        bfly_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_idle("reset_idle");
        step();
        check_idle("reset_idle_hold");

        run_frame(1'b0, 1'b0, 35);

        // Abort mid-COMPUTE; start coincides with reset and must lose.
        load_samples();
        step();
        step();
        check("mid_compute_valid", 32'(bfly_valid), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check_idle("reset_mid_compute");
        step();
        check_idle("reset_beats_start");

        run_frame(1'b1, 1'b1, 38);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
